// File: rtl/fetch_stage_pkg.sv
// Shared pipeline constants and the fetch buffer entry type.
package fetch_stage_pkg;

  localparam int unsigned PC_W       = 12;
  localparam int unsigned INST_W     = 32;
  localparam int unsigned STAT_W     = 16;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CNT_W = 2;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   next_pc;
  } fetch_entry_t;

  // Word-address increment, wrapping at the top of the address space.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch (master) and memory (slave).
interface fetch_stage_if import fetch_stage_pkg::*; ();

  logic              req;
  logic [PC_W-1:0]   addr;
  logic              valid;
  logic [INST_W-1:0] data;

  modport master (output req, output addr, input valid, input data);
  modport slave  (input req, input addr, output valid, output data);

endinterface

// File: rtl/fetch_buf.sv
// Two-entry instruction buffer; slot0 is always the head.
module fetch_buf import fetch_stage_pkg::*; (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  fetch_entry_t          data_i,
  input  logic                  pop_i,
  output fetch_entry_t          head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  fetch_entry_t          slot0_q, slot0_d, slot1_q, slot1_d;
  logic [FIFO_CNT_W-1:0] cnt_q, cnt_d, remain;
  logic                  do_pop, do_push;

  // Shift-on-pop update; a push lands in the first slot left free after the pop.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q != FIFO_CNT_W'(FIFO_DEPTH)) || do_pop);
    remain  = cnt_q - FIFO_CNT_W'(do_pop);
    if (do_pop) slot0_d = slot1_q;
    if (do_push) begin
      if (remain == '0) slot0_d = data_i;
      else              slot1_d = data_i;
    end
    cnt_d = remain + FIFO_CNT_W'(do_push);
    if (clear_i) cnt_d = '0;
  end

  // Occupancy is reset/cleared; payload slots need no reset since empty masks them.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
    slot0_q <= slot0_d;
    slot1_q <= slot1_d;
  end

  assign head_o  = slot0_q;
  assign full_o  = (cnt_q == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues sequential imem reads, buffers responses,
// flushes on redirect. Optional delivered-instruction counter: FETCH_STATS_EN.
// MAX_OUTSTANDING must not exceed the buffer depth.
module fetch_stage import fetch_stage_pkg::*; #(
  parameter logic [PC_W-1:0] RESET_PC        = 12'd0,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imemReq,
  output logic [PC_W-1:0]   imemAddr,
  input  logic              imemValid,
  input  logic [INST_W-1:0] imemData,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirectPc,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   seqNextPc,
  output logic              fdEnable,
  output logic [STAT_W-1:0] fetchCount
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [PC_W-1:0]       pc_q, pc_d, exp_pc_q, exp_pc_d;
  logic [CNT_W-1:0]      inflight_q, inflight_d, kill_q, kill_d;
  logic                  resp, push, pop, req;
  logic                  buf_full, buf_empty;
  logic [FIFO_CNT_W-1:0] buf_count;
  fetch_entry_t          head, push_entry;

  // inflight counts every unanswered request (killed or not); exp_pc is the
  // address of the next response that will be kept.
  always_comb begin
    resp       = imemValid && (inflight_q != '0);
    pop        = reset && !buf_empty && !stall && !redirect;
    req        = reset && !redirect &&
                 ((32'(inflight_q) + 32'(buf_count) - 32'(pop)) < MAX_OUTSTANDING);
    push       = resp && !redirect && (kill_q == '0);
    push_entry = '{inst: imemData, next_pc: pc_inc(exp_pc_q)};
    pc_d       = pc_q;
    exp_pc_d   = exp_pc_q;
    kill_d     = kill_q;
    inflight_d = inflight_q + CNT_W'(req) - CNT_W'(resp);
    if (redirect) begin
      pc_d     = redirectPc;
      exp_pc_d = redirectPc;
      kill_d   = inflight_q - CNT_W'(resp);
    end else begin
      if (req)  pc_d     = pc_inc(pc_q);
      if (push) exp_pc_d = pc_inc(exp_pc_q);
      if (resp && (kill_q != '0)) kill_d = kill_q - CNT_W'(1);
    end
  end

  // Fetch control state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      exp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      kill_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      exp_pc_q   <= exp_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  fetch_buf u_buf (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clear_i (redirect),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

  // Issue gating must keep pushes out of a full buffer.
  always_ff @(posedge clock) begin
    if (reset) assert (!(push && buf_full && !pop));
  end

  assign imemReq   = req;
  assign imemAddr  = pc_q;
  assign fdEnable  = pop;
  assign inst      = (reset && !buf_empty) ? head.inst : NOP_INST;
  assign seqNextPc = !reset ? RESET_PC : (buf_empty ? pc_q : head.next_pc);

`ifdef FETCH_STATS_EN
  logic [STAT_W-1:0] fetch_cnt_q;

  // Saturating count of delivered instructions.
  always_ff @(posedge clock) begin
    if (!reset)                                    fetch_cnt_q <= '0;
    else if (pop && (fetch_cnt_q != {STAT_W{1'b1}})) fetch_cnt_q <= fetch_cnt_q + STAT_W'(1);
  end

  assign fetchCount = fetch_cnt_q;
`else
  assign fetchCount = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: queue-based reference model plus an
// in-order variable-latency instruction memory.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [11:0] RST_PC  = 12'h000;
  localparam int          MAX_OUT = 2;
`ifdef FETCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect;
  logic [11:0] redirect_pc;
  logic [31:0] inst;
  logic [11:0] seq_pc;
  logic        fd_en;
  logic [15:0] fetch_cnt;

  fetch_stage_if mem_bus ();

  fetch_stage #(.RESET_PC(RST_PC), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clock      (clk),
    .reset      (rst_n),
    .imemReq    (mem_bus.req),
    .imemAddr   (mem_bus.addr),
    .imemValid  (mem_bus.valid),
    .imemData   (mem_bus.data),
    .stall      (stall),
    .redirect   (redirect),
    .redirectPc (redirect_pc),
    .inst       (inst),
    .seqNextPc  (seq_pc),
    .fdEnable   (fd_en),
    .fetchCount (fetch_cnt)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [11:0] addr; bit kill; } fly_t;
  typedef struct { logic [31:0] inst; logic [11:0] npc; } ent_t;
  typedef struct { logic [11:0] addr; int ready; } mreq_t;

  fly_t  fly_q[$];
  ent_t  fifo_q[$];
  mreq_t mem_q[$];

  logic [11:0] m_pc;
  int          m_cnt, cyc, n_assert, n_fail;
  int          lat_min, lat_max, valid_pct, fd_seen;
  bit          first_pending;
  logic [11:0] first_pc;

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {a, 4'hA, ~a, 4'h5};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input logic r, input logic s, input logic rd, input logic [11:0] rp);
    logic        v, e_req, e_fd;
    logic [31:0] d, e_inst;
    logic [11:0] e_seq;
    fly_t        f;
    int          occ;
    v = 1'b0;
    d = $urandom;
    if (!r) mem_q.delete();
    else if (mem_q.size() > 0 && mem_q[0].ready <= cyc &&
             $urandom_range(0, 99) < valid_pct) begin
      v = 1'b1;
      d = mem_word(mem_q[0].addr);
      mem_q.delete(0);
    end
    rst_n         = r;
    stall         = s;
    redirect      = rd;
    redirect_pc   = rp;
    mem_bus.valid = v;
    mem_bus.data  = d;
    #1;
    if (!r) begin
      e_req = 1'b0; e_fd = 1'b0; e_inst = NOP_INST; e_seq = RST_PC;
    end else begin
      e_fd = (fifo_q.size() > 0) && !s && !rd;
      if (fifo_q.size() > 0) begin
        e_inst = fifo_q[0].inst; e_seq = fifo_q[0].npc;
      end else begin
        e_inst = NOP_INST; e_seq = m_pc;
      end
      occ   = fly_q.size() + fifo_q.size() - int'(e_fd);
      e_req = !rd && (occ < MAX_OUT);
    end
    check("imemReq", 32'(mem_bus.req), 32'(e_req));
    check("fdEnable", 32'(fd_en), 32'(e_fd));
    check("inst", inst, e_inst);
    check("seqNextPc", 32'(seq_pc), 32'(e_seq));
    if (r && e_req) check("imemAddr", 32'(mem_bus.addr), 32'(m_pc));
    if (r) check("fetchCount", 32'(fetch_cnt), STATS ? 32'(m_cnt) : 32'd0);
    if (e_fd && first_pending) begin
      check("first_inst", inst, mem_word(first_pc));
      check("first_seq", 32'(seq_pc), 32'(12'(first_pc + 12'd1)));
      first_pending = 1'b0;
    end
    if (fd_en === 1'b1) fd_seen++;
    if (!r) begin
      m_pc = RST_PC; m_cnt = 0;
      fly_q.delete(); fifo_q.delete();
    end else begin
      if (e_fd) begin
        fifo_q.delete(0);
        if (m_cnt < 65535) m_cnt++;
      end
      if (v && fly_q.size() > 0) begin
        f = fly_q[0];
        fly_q.delete(0);
        if (!f.kill && !rd) fifo_q.push_back('{d, 12'(f.addr + 12'd1)});
      end
      if (rd) begin
        fifo_q.delete();
        foreach (fly_q[i]) fly_q[i].kill = 1'b1;
        m_pc = rp;
      end else if (e_req) begin
        fly_q.push_back('{m_pc, 1'b0});
        mem_q.push_back('{m_pc, cyc + 1 + int'($urandom_range(lat_max, lat_min))});
        m_pc = 12'(m_pc + 12'd1);
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_assert = 0; n_fail = 0; cyc = 0; m_cnt = 0; m_pc = RST_PC;
    lat_min = 0; lat_max = 0; valid_pct = 100; fd_seen = 0;
    first_pending = 1'b0; first_pc = RST_PC;

    // Reset, then 1-cycle memory streaming from RESET_PC.
    repeat (3) step(1'b0, 1'b0, 1'b0, 12'h0);
    first_pending = 1'b1; first_pc = RST_PC;
    repeat (12) step(1'b1, 1'b0, 1'b0, 12'h0);

    // Stall with a full buffer, then release.
    repeat (5) step(1'b1, 1'b1, 1'b0, 12'h0);
    repeat (6) step(1'b1, 1'b0, 1'b0, 12'h0);

    // Redirect to 0x100 while slow responses are in flight.
    lat_min = 2; lat_max = 2;
    repeat (6) step(1'b1, 1'b0, 1'b0, 12'h0);
    step(1'b1, 1'b0, 1'b1, 12'h100);
    first_pending = 1'b1; first_pc = 12'h100;
    lat_min = 0; lat_max = 0;
    repeat (10) step(1'b1, 1'b0, 1'b0, 12'h0);

    // PC wrap through 0xFFF.
    step(1'b1, 1'b0, 1'b1, 12'hFFE);
    first_pending = 1'b1; first_pc = 12'hFFE;
    repeat (8) step(1'b1, 1'b0, 1'b0, 12'h0);

    // Reset mid-stream with responses pending.
    lat_min = 2; lat_max = 2;
    repeat (5) step(1'b1, 1'b0, 1'b0, 12'h0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 12'h0);
    first_pending = 1'b1; first_pc = RST_PC;
    lat_min = 0; lat_max = 1;
    repeat (8) step(1'b1, 1'b0, 1'b0, 12'h0);

    // Random traffic: stalls, redirects, variable latency, occasional reset.
    lat_min = 0; lat_max = 3; valid_pct = 70;
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 19) == 0), 12'($urandom));
    end

    // Exactly ten deliveries after reset.
    lat_min = 0; lat_max = 0; valid_pct = 100;
    repeat (2) step(1'b0, 1'b0, 1'b0, 12'h0);
    fd_seen = 0;
    for (int i = 0; i < 100 && fd_seen < 10; i++) step(1'b1, 1'b0, 1'b0, 12'h0);
    check("deliveries", 32'(fd_seen), 32'd10);
    check("fetchCount_10", 32'(fetch_cnt), STATS ? 32'd10 : 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
